// File: rtl/counter_pkg.sv
// Shared encodings for the modulo up/down counter: mode selector values,
// one-shot FSM states and a small mode-decode helper.
package counter_pkg;

    // Counting modes; the reserved code behaves exactly like WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    // One-shot sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // ONESHOT steps clamp at the terminal exactly like SATURATE.
    function automatic logic is_clamping_mode(input logic [1:0] m);
        return (m == MODE_SAT) || (m == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/counter_step.sv
// Combinational next-value generator. Works in N+1 bits so that overshoot
// past limit and undershoot below zero are both visible before folding
// the result back into 0..limit.
module counter_step
    import counter_pkg::*;
#(
    parameter int N    = 4,
    parameter int STEP = 1
) (
    input  logic [N-1:0] count_i,
    input  logic         dir_i,
    input  logic [N-1:0] limit_i,
    input  logic [1:0]   mode_i,
    output logic [N-1:0] next_o,
    output logic         tc_o,
    output logic         at_term_o
);

    localparam int W = N + 1;
    localparam logic [W-1:0] STEP_X = W'(STEP);

    // Up step folded modulo m; s_mod is already reduced below m.
    function automatic logic [W-1:0] wrap_up(input logic [W-1:0] c,
                                             input logic [W-1:0] s_mod,
                                             input logic [W-1:0] m);
        logic [W-1:0] s;
        s = c + s_mod;
        return (s >= m) ? (s - m) : s;
    endfunction

    // Down step folded modulo m; c + m cannot overflow W bits since c <= limit.
    function automatic logic [W-1:0] wrap_down(input logic [W-1:0] c,
                                               input logic [W-1:0] s_mod,
                                               input logic [W-1:0] m);
        return (c >= s_mod) ? (c - s_mod) : (c + m - s_mod);
    endfunction

    // Up step clamped at lim.
    function automatic logic [W-1:0] sat_up(input logic [W-1:0] c,
                                            input logic [W-1:0] s,
                                            input logic [W-1:0] lim);
        logic [W-1:0] sum;
        sum = c + s;
        return (sum > lim) ? lim : sum;
    endfunction

    // Down step clamped at zero.
    function automatic logic [W-1:0] sat_down(input logic [W-1:0] c,
                                              input logic [W-1:0] s);
        return (c < s) ? '0 : (c - s);
    endfunction

    logic [W-1:0] cnt_x;
    logic [W-1:0] lim_x;
    logic [W-1:0] mod_x;
    logic [W-1:0] step_m;
    logic [W-1:0] term_x;
    logic [W-1:0] next_x;
    logic         pass;
    logic         clamp;

    // Next value, step pulse flag and at-terminal flag for the current count.
    always_comb begin
        cnt_x  = {1'b0, count_i};
        lim_x  = {1'b0, limit_i};
        mod_x  = lim_x + W'(1);
        // A step larger than the modulus is equivalent to its remainder.
        step_m = STEP_X % mod_x;
        clamp  = is_clamping_mode(mode_i);
        term_x = dir_i ? '0 : lim_x;
        pass   = dir_i ? (cnt_x < STEP_X) : ((cnt_x + STEP_X) > lim_x);
        next_x = cnt_x;
        tc_o   = 1'b0;
        if (cnt_x > lim_x) begin
            // limit was lowered under the count: pull back silently.
            next_x = lim_x;
        end else if (clamp) begin
            next_x = dir_i ? sat_down(cnt_x, STEP_X) : sat_up(cnt_x, STEP_X, lim_x);
            tc_o   = (next_x == term_x) && (cnt_x != term_x);
        end else begin
            next_x = dir_i ? wrap_down(cnt_x, step_m, mod_x) : wrap_up(cnt_x, step_m, mod_x);
            tc_o   = pass;
        end
        next_o    = N'(next_x);
        at_term_o = (cnt_x == term_x);
    end

endmodule

// File: rtl/counter_mod_ud.sv
// Modulo up/down counter with WRAP, SATURATE and ONESHOT modes, a
// clamped synchronous load and a registered terminal pulse.
module counter_mod_ud
    import counter_pkg::*;
#(
    parameter int           N       = 4,
    parameter int           STEP    = 1,
    parameter logic [N-1:0] RST_VAL = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         dir,
    input  logic [1:0]   mode,
    input  logic [N-1:0] limit,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    output logic [N-1:0] count,
    output logic         tc,
    output logic         busy,
    output logic         done
);

    // Keep a value inside the legal range 0..lim.
    function automatic logic [N-1:0] clamp_to_limit(input logic [N-1:0] v,
                                                    input logic [N-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    state_e       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic [N-1:0] step_next;
    logic         step_tc;
    logic         step_at_term;
    logic [N-1:0] rst_count;
    logic         oneshot;

    assign rst_count = clamp_to_limit(RST_VAL, limit);

    counter_step #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .count_i   (count_q),
        .dir_i     (dir),
        .limit_i   (limit),
        .mode_i    (mode),
        .next_o    (step_next),
        .tc_o      (step_tc),
        .at_term_o (step_at_term)
    );

    // Next count, pulse and FSM state with priority load > start > step.
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        tc_d    = 1'b0;
        oneshot = (mode == MODE_ONESHOT);
        if (load) begin
            count_d = clamp_to_limit(load_val, limit);
            state_d = ST_IDLE;
        end else if (start && oneshot && (state_q == ST_IDLE)) begin
            count_d = dir ? limit : '0;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!oneshot) begin
                        // Mode changed under a running shot: abort, keep count.
                        state_d = ST_IDLE;
                    end else if (en) begin
                        if (step_at_term) begin
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = step_next;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    // Free-running modes; an idle one-shot holds.
                    if (en && !oneshot) begin
                        count_d = step_next;
                        tc_d    = step_tc;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset overriding every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= rst_count;
            tc_q    <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);

endmodule
